// File: rtl/traceback_walker_pkg.sv
// Shared types for the traceback walker: direction-cell fields, op codes, walk layers, FSM states.
package traceback_walker_pkg;

  localparam int N                = 4;
  localparam int LOG_N            = 2;
  localparam int DIRECTION_WIDTH  = 5;
  localparam int ADDRESS_WIDTH    = 10;
  localparam int MEM_AMOUNT_WIDTH = 4;

  // Direction cell: [1:0] H source, [2] gap piece, [3] ins-extend, [4] del-extend
  localparam logic [1:0] SRC_DIAG = 2'b00;
  localparam logic [1:0] SRC_INS  = 2'b01;
  localparam logic [1:0] SRC_DEL  = 2'b10;
  localparam logic [1:0] SRC_STOP = 2'b11;
  localparam int BIT_INS_EXT = 3;
  localparam int BIT_DEL_EXT = 4;

  typedef logic [ADDRESS_WIDTH-1:0]      addr_t;
  typedef logic [ADDRESS_WIDTH:0]        cnt_t;
  typedef logic [MEM_AMOUNT_WIDTH-1:0]   blk_t;
  typedef logic [N*DIRECTION_WIDTH-1:0]  row_t;

  typedef enum logic [1:0] {OP_M = 2'd0, OP_I = 2'd1, OP_D = 2'd2} op_e;
  typedef enum logic [1:0] {LAYER_H = 2'd0, LAYER_I = 2'd1, LAYER_D = 2'd2} layer_e;
  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_WAIT, ST_DECODE, ST_EMIT, ST_FINISH
  } state_e;

endpackage

// File: rtl/traceback_row_cache.sv
// One-row cache of direction blocks k0 (block) and k1 (block-1) with hit detection and lane select.
// Loads in the cycle load is high; hit and cell fields are combinational from the current x/y.
module traceback_row_cache
  import traceback_walker_pkg::*;
(
  input  logic             clk,
  input  logic             reset_i,
  input  logic             invalidate,
  input  logic             load,
  input  blk_t             blk,
  input  addr_t            row,
  input  logic [LOG_N-1:0] lane,
  input  row_t             row_k0,
  input  row_t             row_k1,
  output logic             hit,
  output logic [1:0]       src,
  output logic             ins_ext,
  output logic             del_ext
);
  localparam int BW = $clog2(N*DIRECTION_WIDTH);

  row_t          k0_q, k1_q, sel_row;
  blk_t          tag_blk_q;
  addr_t         tag_row_q;
  logic          tag_vld_q;
  logic          hit0, hit1;
  logic [BW-1:0] base;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      k0_q      <= '0;
      k1_q      <= '0;
      tag_blk_q <= '0;
      tag_row_q <= '0;
      tag_vld_q <= 1'b0;
    end else if (invalidate) begin
      tag_vld_q <= 1'b0;
    end else if (load) begin
      k0_q      <= row_k0;
      k1_q      <= row_k1;
      tag_blk_q <= blk;
      tag_row_q <= row;
      tag_vld_q <= 1'b1;
    end
  end

  // k1 holds block tag-1, so a walk leftwards across a block edge still hits
  assign hit0 = tag_vld_q && (tag_row_q == row) && (tag_blk_q == blk);
  assign hit1 = tag_vld_q && (tag_row_q == row) && (tag_blk_q != '0) &&
                ((tag_blk_q - blk_t'(1)) == blk);
  assign hit  = hit0 | hit1;

  assign sel_row = hit0 ? k0_q : k1_q;
  assign base    = BW'(lane) * BW'(DIRECTION_WIDTH);
  assign src     = sel_row[base +: 2];
  assign ins_ext = sel_row[base + BW'(BIT_INS_EXT)];
  assign del_ext = sel_row[base + BW'(BIT_DEL_EXT)];

endmodule

// File: rtl/traceback_walker.sv
// Walks direction memories back from (tb_x, tb_y), emitting M/I/D ops; miss costs 2 cycles, hit decodes the cycle after a handshake.
// op/op_last held stable while op_ready is low; coordinates only move on the handshake.
module traceback_walker
  import traceback_walker_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset_i,
  input  logic                        start,
  input  logic [ADDRESS_WIDTH-1:0]    tb_x,
  input  logic [ADDRESS_WIDTH-1:0]    tb_y,
  output logic                        busy,
  output logic [MEM_AMOUNT_WIDTH-1:0] mem_block_num,
  output logic [ADDRESS_WIDTH-1:0]    row_num,
  input  logic [N*DIRECTION_WIDTH-1:0] row_k0,
  input  logic [N*DIRECTION_WIDTH-1:0] row_k1,
  output logic                        op_valid,
  input  logic                        op_ready,
  output logic [1:0]                  op,
  output logic                        op_last,
  output logic                        done,
  output logic [ADDRESS_WIDTH:0]      op_count
);
  state_e     state_q, state_d;
  layer_e     layer_q, layer_d;
  addr_t      x_q, y_q;
  op_e        op_q, dec_op;
  cnt_t       op_count_q;
  logic       op_last_q, dec_last, dec_emit, dec_stop;
  logic       accept, op_fire;
  logic       hit, ins_ext, del_ext;
  logic [1:0] src;

  assign accept        = (state_q == ST_IDLE) && start;
  assign op_fire       = (state_q == ST_EMIT) && op_ready;
  assign mem_block_num = x_q[LOG_N +: MEM_AMOUNT_WIDTH];
  assign row_num       = y_q;

  traceback_row_cache u_cache (
    .clk        (clk),
    .reset_i    (reset_i),
    .invalidate (accept),
    .load       (state_q == ST_WAIT),
    .blk        (mem_block_num),
    .row        (row_num),
    .lane       (x_q[LOG_N-1:0]),
    .row_k0     (row_k0),
    .row_k1     (row_k1),
    .hit        (hit),
    .src        (src),
    .ins_ext    (ins_ext),
    .del_ext    (del_ext)
  );

  // The gap piece is already folded into the extend bits by the array, so no copy is kept
  always_comb begin
    dec_emit = 1'b0;
    dec_op   = OP_M;
    dec_last = 1'b0;
    dec_stop = 1'b0;
    layer_d  = layer_q;
    unique case (layer_q)
      LAYER_H: begin
        unique case (src)
          SRC_DIAG: begin
            dec_emit = 1'b1;
            dec_last = (x_q == '0) || (y_q == '0);
          end
          SRC_INS: layer_d  = LAYER_I;
          SRC_DEL: layer_d  = LAYER_D;
          default: dec_stop = 1'b1;
        endcase
      end
      LAYER_I: begin
        dec_emit = 1'b1;
        dec_op   = OP_I;
        dec_last = (y_q == '0);
        layer_d  = ins_ext ? LAYER_I : LAYER_H;
      end
      LAYER_D: begin
        dec_emit = 1'b1;
        dec_op   = OP_D;
        dec_last = (x_q == '0);
        layer_d  = del_ext ? LAYER_D : LAYER_H;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_WAIT;
      ST_WAIT:   state_d = ST_DECODE;
      ST_DECODE: begin
        if (!hit)          state_d = ST_FETCH;
        else if (dec_emit) state_d = ST_EMIT;
        else if (dec_stop) state_d = ST_FINISH;
      end
      ST_EMIT:   if (op_ready) state_d = op_last_q ? ST_FINISH : ST_DECODE;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    op_valid = (state_q == ST_EMIT);
    op_last  = op_last_q && (state_q == ST_EMIT);
    done     = (state_q == ST_FINISH);
    op       = op_q;
    op_count = op_count_q;
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      x_q        <= '0;
      y_q        <= '0;
      layer_q    <= LAYER_H;
      op_q       <= OP_M;
      op_last_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      if (accept) begin
        x_q        <= tb_x;
        y_q        <= tb_y;
        layer_q    <= LAYER_H;
        op_last_q  <= 1'b0;
        op_count_q <= '0;
      end
      if ((state_q == ST_DECODE) && hit) begin
        layer_q <= layer_d;
        if (dec_emit) begin
          op_q      <= dec_op;
          op_last_q <= dec_last;
        end
      end
      if (op_fire) begin
        op_count_q <= op_count_q + cnt_t'(1);
        // A boundary op ends the walk in place rather than wrapping the coordinate
        if (!op_last_q) begin
          if (op_q != OP_I) x_q <= x_q - addr_t'(1);
          if (op_q != OP_D) y_q <= y_q - addr_t'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_traceback_walker.sv
// Directed bench for traceback_walker: a walk-level reference model feeds a per-cycle op scoreboard.
module tb_traceback_walker;
  import traceback_walker_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start = 1'b0;
  addr_t       tb_x = '0, tb_y = '0;
  logic        busy, op_valid, op_last, done;
  blk_t        mem_block_num;
  addr_t       row_num;
  row_t        row_k0 = '0, row_k1 = '0;
  logic        op_ready = 1'b1;
  logic [1:0]  op;
  cnt_t        op_count;

  logic [4:0]  mem [64][16];
  logic [2:0]  exp_q [$];
  int          exp_cnt = 0;
  int          hs_cyc [$];
  int          cyc = 0, n_checks = 0, n_pass = 0;
  int          n_hs = 0, stall_cnt = 0, done_cyc = -1, bp_left = 5;
  bit          done_seen = 0, valid_seen = 0, stalled = 0, bp_arm = 0;
  logic [2:0]  held_op;
  logic [13:0] held_addr;

  traceback_walker dut (
    .clk(clk), .reset_i(reset_i), .start(start), .tb_x(tb_x), .tb_y(tb_y),
    .busy(busy), .mem_block_num(mem_block_num), .row_num(row_num),
    .row_k0(row_k0), .row_k1(row_k1), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .op_last(op_last), .done(done), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  function automatic row_t pack_row(input int blk, input int row);
    row_t r;
    for (int j = 0; j < N; j++) r[j*DIRECTION_WIDTH +: DIRECTION_WIDTH] = mem[blk*N+j][row];
    return r;
  endfunction

  // Synchronous-read direction RAM, one cycle latency
  always @(posedge clk) begin
    row_k0 <= pack_row(int'(mem_block_num), int'(row_num[3:0]));
    row_k1 <= (mem_block_num == '0) ? '0 : pack_row(int'(mem_block_num) - 1, int'(row_num[3:0]));
  end

  // Consumer: when armed, refuses the second op for five cycles
  always @(posedge clk) begin
    #1;
    if (!bp_arm) begin
      bp_left  = 5;
      op_ready = 1'b1;
    end else if (op_valid && n_hs == 1 && bp_left > 0) begin
      op_ready = 1'b0;
      bp_left--;
    end else begin
      op_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset_i) begin
      if (start && !busy) begin
        hs_cyc.delete();
        done_seen = 0; done_cyc = -1; stall_cnt = 0; n_hs = 0; stalled = 0; valid_seen = 0;
      end
      if (stalled) begin
        chk("hold_op", 32'({op_last, op}), 32'(held_op));
        chk("hold_coord", 32'({mem_block_num, row_num}), 32'(held_addr));
      end
      stalled = op_valid && !op_ready;
      if (stalled) begin
        held_op   = {op_last, op};
        held_addr = {mem_block_num, row_num};
        stall_cnt++;
      end
      if (op_valid) valid_seen = 1;
      if (op_valid && op_ready) begin
        chk("op_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          logic [2:0] e;
          e = exp_q.pop_front();
          chk("op", 32'(op), 32'(e[1:0]));
          chk("op_last", 32'(op_last), 32'(e[2]));
        end
        hs_cyc.push_back(cyc);
        n_hs++;
      end
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
        chk("op_count", 32'(op_count), 32'(exp_cnt));
        chk("ops_left", 32'(exp_q.size()), 0);
      end
    end
  end

  task automatic fill_diag();
    for (int c = 0; c < 64; c++) for (int r = 0; r < 16; r++) mem[c][r] = 5'b00000;
  endtask

  // Walk-level reference: follows the direction rules cell by cell, no timing
  task automatic model_walk(input int sx, input int sy);
    int x = sx, y = sy, layer = 0;
    bit fin = 0;
    logic [4:0] c;
    logic last;
    exp_q.delete();
    for (int g = 0; g < 256 && !fin; g++) begin
      c = mem[x][y];
      last = 1'b0;
      if (layer == 0) begin
        if (c[1:0] == 2'd3) fin = 1;
        else if (c[1:0] == 2'd1) layer = 1;
        else if (c[1:0] == 2'd2) layer = 2;
        else begin
          last = (x == 0 || y == 0);
          exp_q.push_back({last, 2'd0});
          if (!last) begin x--; y--; end
        end
      end else if (layer == 1) begin
        last = (y == 0);
        exp_q.push_back({last, 2'd1});
        layer = c[3] ? 1 : 0;
        if (!last) y--;
      end else begin
        last = (x == 0);
        exp_q.push_back({last, 2'd2});
        layer = c[4] ? 2 : 0;
        if (!last) x--;
      end
      if (last) fin = 1;
    end
    exp_cnt = exp_q.size();
  endtask

  task automatic kick(input int sx, input int sy, output int t0);
    model_walk(sx, sy);
    @(posedge clk); #1;
    tb_x = addr_t'(sx); tb_y = addr_t'(sy); start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 400 && !done_seen; i++) @(posedge clk);
    chk({name, "_done"}, 32'(done_seen), 1);
  endtask

  task automatic check_timing(input string name, input int t0, input int first, input int tail);
    int bad = 0;
    chk({name, "_has_ops"}, 32'(hs_cyc.size() > 0), 1);
    if (hs_cyc.size() > 0) begin
      for (int i = 1; i < hs_cyc.size(); i++) if (hs_cyc[i] - hs_cyc[i-1] != 2) bad++;
      chk({name, "_refetch"}, 32'(bad), 0);
      chk({name, "_first_op_cyc"}, 32'(hs_cyc[0] - t0), 32'(first));
      chk({name, "_done_after_last"}, 32'(done_cyc - hs_cyc[hs_cyc.size()-1]), 32'(tail));
    end
  endtask

  initial begin
    int t0;
    reset_i = 1'b1;
    #1 reset_i = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(op_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(op_count), 0);
    chk("rst_addr", 32'({mem_block_num, row_num}), 0);
    chk("rst_op", 32'({op_last, op}), 0);
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b1;

    // Diagonal run into a stop cell
    fill_diag(); mem[2][2] = 5'b00011;
    model_walk(5, 5);
    chk("t1_model_len", 32'(exp_cnt), 3);
    chk("t1_model_ops", 32'({exp_q[0], exp_q[1], exp_q[2]}), 0);
    kick(5, 5, t0); wait_done("t1");
    chk("t1_first_op_cyc", 32'(hs_cyc.size() > 0 ? hs_cyc[0] - t0 : -1), 4);

    // Deletion chain running off the left edge
    fill_diag(); mem[3][3] = 5'b10010; mem[2][3] = 5'b10000; mem[1][3] = 5'b10000;
    model_walk(3, 3);
    chk("t2_model", 32'({exp_q[0], exp_q[1], exp_q[2], exp_q[3]}), 32'({3'b010, 3'b010, 3'b010, 3'b110}));
    kick(3, 3, t0); wait_done("t2");

    // Long-piece insertion, then one match
    fill_diag(); mem[2][6] = 5'b01101; mem[1][3] = 5'b00011;
    model_walk(2, 6);
    chk("t3_model", 32'({exp_q[0], exp_q[1], exp_q[2]}), 32'({3'b001, 3'b001, 3'b000}));
    kick(2, 6, t0); wait_done("t3");

    // Row 0 deletion run 5..0 crosses the block edge inside one fetch
    fill_diag(); mem[5][0] = 5'b10010;
    for (int c = 1; c < 5; c++) mem[c][0] = 5'b10000;
    kick(5, 0, t0); wait_done("t4");
    chk("t4_ops", 32'(n_hs), 6);
    check_timing("t4", t0, 5, 1);

    // Crossing 8->7 on row 1, with a start pulse while busy
    fill_diag(); mem[9][1] = 5'b10010; mem[8][1] = 5'b10000; mem[6][1] = 5'b00011;
    kick(9, 1, t0);
    repeat (4) @(posedge clk);
    #1; tb_x = 10'd3; tb_y = 10'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done("t5");
    chk("t5_ops", 32'(n_hs), 3);
    check_timing("t5", t0, 5, 2);

    // Backpressure on the second op
    fill_diag(); mem[2][2] = 5'b00011;
    bp_arm = 1;
    kick(5, 5, t0); wait_done("t6");
    bp_arm = 0;
    chk("t6_stall_cycles", 32'(stall_cnt), 5);

    // Stop at the start cell
    fill_diag(); mem[4][4] = 5'b00011;
    kick(4, 4, t0); wait_done("t7");
    chk("t7_done_cyc", 32'(done_cyc - t0), 4);
    chk("t7_no_valid", 32'(valid_seen), 0);

    // Reset mid-walk
    fill_diag(); mem[2][2] = 5'b00011;
    kick(5, 5, t0);
    repeat (4) @(posedge clk);
    #3 reset_i = 1'b0;
    #1;
    chk("t8_busy", 32'(busy), 0);
    chk("t8_outs", 32'({op_valid, op_last, op, done}), 0);
    chk("t8_count_addr", 32'({op_count, mem_block_num, row_num}), 0);
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b1;
    repeat (10) @(posedge clk);
    chk("t8_no_done", 32'(done_seen), 0);
    chk("t8_idle", 32'(busy), 0);

    // Match running into row 0 is the boundary op
    fill_diag();
    model_walk(2, 1);
    chk("t9_model", 32'({exp_q[0], exp_q[1]}), 32'({3'b000, 3'b100}));
    kick(2, 1, t0); wait_done("t9");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
